hi_read_rx_xcorr_multi: RTL and testbench

Parametrised HF reader-mode I/Q correlator for the 13.56 MHz receive path. It correlates the ADC stream against in-phase and quadrature square-wave references at a runtime-selectable subcarrier (848/424/212 kHz) over a configurable window. Each window result is scaled with runtime gain and signed saturation, optionally tagged with the snooped reader AM bit, and serialised to the ARM over SSP as two OUT_W-bit frames. It sits between the ADC and the SSP link, in place of the fixed 848/424 kHz correlator. Carrier and power-pin drive stay in the top-level mode mux.

---
 rtl/hi_read_rx_xcorr_multi.sv | 130 +++++++++++++
 tb/tb_hi_read_rx_xcorr_multi.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/hi_read_rx_xcorr_multi.sv
// hi_read_rx_xcorr_multi: I/Q square-wave correlator over the ADC stream at a selectable subcarrier,
// scaled and saturated per window and serialised as two signed words over SSP.
module hi_read_rx_xcorr_multi #(
    parameter int ADC_W        = 8,
    parameter int OUT_W        = 8,
    parameter int WIN_LOG2     = 6,
    parameter int HYST_TIMEOUT = 4095
) (
    input  logic             ck_1356meg,
    input  logic             reset_n,
    input  logic [ADC_W-1:0] adc_d,
    input  logic [1:0]       subcarrier_sel,
    input  logic [1:0]       gain,
    input  logic             snoop,
    output logic [OUT_W-1:0] corr_i,
    output logic [OUT_W-1:0] corr_q,
    output logic             corr_valid,
    output logic             ssp_clk,
    output logic             ssp_frame,
    output logic             ssp_din,
    output logic             dbg
);
    localparam int ACC_W      = ADC_W + WIN_LOG2 + 1;
    localparam int BASE_SHIFT = ACC_W - OUT_W;
    localparam int SH_W       = $clog2(ACC_W + 1);
    localparam int LR_W       = $clog2(HYST_TIMEOUT + 1);
    localparam int SR_W       = 2 * OUT_W;
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;
    localparam logic [WIN_LOG2-1:0] MID   = WIN_LOG2'(2 ** (WIN_LOG2 - 1));
    localparam logic [WIN_LOG2-3:0] WORD2 = (WIN_LOG2 - 2)'(OUT_W);

    logic [WIN_LOG2-1:0]     cnt_q, cnt_d;
    logic [1:0]              sel_q, sel_d, gain_q, gain_d;
    logic                    snoop_q, snoop_d;
    logic signed [ACC_W-1:0] acci_q, acci_d, accq_q, accq_d;
    logic [OUT_W-1:0]        corr_i_q, corr_i_d, corr_q_q, corr_q_d;
    logic                    valid_q, valid_d;
    logic [SR_W-1:0]         sr_q, sr_d;
    logic                    sclk_q, sclk_d, frame_q, frame_d;
    logic                    h_q, h_d, h_mid_q, h_mid_d, h_prev_q, h_prev_d;
    logic [LR_W-1:0]         lr_q, lr_d;
    logic                    wrap, ph_i, ph_lo, sub_q, all1, all0, tmo;
    logic signed [ACC_W-1:0] smp;
    logic [SH_W-1:0]         sh;

    function automatic logic [OUT_W-1:0] scale(input logic signed [ACC_W-1:0] a, input logic [SH_W-1:0] n);
        logic signed [ACC_W-1:0] s;
        s = a >>> n;
        return s > SAT_HI ? SAT_HI[OUT_W-1:0] : s < SAT_LO ? SAT_LO[OUT_W-1:0] : s[OUT_W-1:0];
    endfunction

    always_comb begin
        wrap     = cnt_q == '0;
        ph_i     = sel_q == 2'b01 ? cnt_q[4] : sel_q == 2'b10 ? cnt_q[5] : cnt_q[3];
        ph_lo    = sel_q == 2'b01 ? cnt_q[3] : sel_q == 2'b10 ? cnt_q[4] : cnt_q[2];
        sub_q    = ph_i ^ ph_lo;
        smp      = {{(ACC_W - ADC_W){1'b0}}, adc_d};
        sh       = SH_W'(BASE_SHIFT) - SH_W'(gain_q);
        cnt_d    = cnt_q + WIN_LOG2'(1);
        sel_d    = wrap ? subcarrier_sel : sel_q;
        gain_d   = wrap ? gain : gain_q;
        snoop_d  = wrap ? snoop : snoop_q;
        acci_d   = wrap ? smp : ph_i ? acci_q - smp : acci_q + smp;
        accq_d   = wrap ? smp : sub_q ? accq_q - smp : accq_q + smp;
        // The completed window is scaled with the gain/snoop it was captured with.
        corr_i_d = wrap ? scale(acci_q, sh) : corr_i_q;
        corr_q_d = wrap ? scale(accq_q, sh) : corr_q_q;
        valid_d  = wrap;
        sr_d     = wrap ? (snoop_q ? {corr_i_d[OUT_W-1:1], h_prev_q, corr_q_d[OUT_W-1:1], h_mid_q}
                                   : {corr_i_d, corr_q_d})
                 : cnt_q[1:0] == 2'b00 ? {sr_q[SR_W-2:0], 1'b0} : sr_q;
        sclk_d   = cnt_q[1:0] == 2'b00 ? 1'b1 : cnt_q[1:0] == 2'b10 ? 1'b0 : sclk_q;
        frame_d  = cnt_q[WIN_LOG2-1:2] == '0 || cnt_q[WIN_LOG2-1:2] == WORD2;
        all1     = &adc_d;
        all0     = ~|adc_d;
        tmo      = lr_q == LR_W'(HYST_TIMEOUT);
        // Low-run counter only advances while h is low, so a timeout always means h was low.
        h_d      = all1 | tmo | (h_q & ~all0);
        lr_d     = (h_q | tmo) ? '0 : lr_q + LR_W'(1);
        h_mid_d  = cnt_q == MID ? h_q : h_mid_q;
        h_prev_d = wrap ? h_q : h_prev_q;
    end

    always_ff @(posedge ck_1356meg) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            sel_q    <= 2'b00;
            gain_q   <= 2'b00;
            snoop_q  <= 1'b0;
            acci_q   <= '0;
            accq_q   <= '0;
            corr_i_q <= '0;
            corr_q_q <= '0;
            valid_q  <= 1'b0;
            sr_q     <= '0;
            sclk_q   <= 1'b0;
            frame_q  <= 1'b0;
            h_q      <= 1'b1;
            h_mid_q  <= 1'b0;
            h_prev_q <= 1'b0;
            lr_q     <= '0;
        end else begin
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            gain_q   <= gain_d;
            snoop_q  <= snoop_d;
            acci_q   <= acci_d;
            accq_q   <= accq_d;
            corr_i_q <= corr_i_d;
            corr_q_q <= corr_q_d;
            valid_q  <= valid_d;
            sr_q     <= sr_d;
            sclk_q   <= sclk_d;
            frame_q  <= frame_d;
            h_q      <= h_d;
            h_mid_q  <= h_mid_d;
            h_prev_q <= h_prev_d;
            lr_q     <= lr_d;
        end
    end

    assign corr_i     = corr_i_q;
    assign corr_q     = corr_q_q;
    assign corr_valid = valid_q;
    assign ssp_clk    = sclk_q;
    assign ssp_frame  = frame_q;
    assign ssp_din    = sr_q[SR_W-1];
    assign dbg        = ph_i;
endmodule

// File: tb/tb_hi_read_rx_xcorr_multi.sv
// tb_hi_read_rx_xcorr_multi: random and directed stimulus against a window-level correlation model.
module tb_hi_read_rx_xcorr_multi;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] adc_d;
    logic [1:0] subcarrier_sel, gain;
    logic       snoop;
    logic [7:0] corr_i, corr_q;
    logic       corr_valid, ssp_clk, ssp_frame, ssp_din, dbg;

    always #5 clk = ~clk;

    hi_read_rx_xcorr_multi dut (
        .ck_1356meg(clk), .reset_n(reset_n), .adc_d(adc_d), .subcarrier_sel(subcarrier_sel),
        .gain(gain), .snoop(snoop), .corr_i(corr_i), .corr_q(corr_q), .corr_valid(corr_valid),
        .ssp_clk(ssp_clk), .ssp_frame(ssp_frame), .ssp_din(ssp_din), .dbg(dbg)
    );

    int total = 0, bad = 0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    int          cnt, win[64], wsel, sh_gain, run_len;
    bit          sh_snoop, h, hmid, hprev;
    int          e_ci, e_cq;
    bit          e_valid, e_clk, e_frame, e_din;
    logic [15:0] word;

    function automatic int kbit(input int sel);
        return sel == 1 ? 4 : sel == 2 ? 5 : 3;
    endfunction

    function automatic int correl(input bit quad);
        int k, s, b1, b0;
        k = kbit(wsel);
        s = 0;
        for (int n = 0; n < 64; n++) begin
            b1 = (n >> k) & 1;
            b0 = (n >> (k - 1)) & 1;
            s += (quad ? b1 != b0 : b1 == 1) ? -win[n] : win[n];
        end
        return s;
    endfunction

    function automatic int scale(input int s, input int g);
        int v;
        v = s >>> (7 - g);
        return v > 127 ? 127 : v < -128 ? -128 : v;
    endfunction

    task automatic model_edge(input int a);
        int c, ci, cq;
        bit nh;
        logic [7:0] bi, bq;
        if (!reset_n) begin
            cnt = 0; wsel = 0; sh_gain = 0; sh_snoop = 0;
            foreach (win[n]) win[n] = 0;
            h = 1; run_len = 0; hmid = 0; hprev = 0;
            e_ci = 0; e_cq = 0; e_valid = 0; e_clk = 0; e_frame = 0; e_din = 0; word = '0;
            return;
        end
        c = cnt;
        nh = a == 255 ? 1'b1 : (!h && run_len == 4095) ? 1'b1 : a == 0 ? 1'b0 : h;
        if (c == 0) begin
            ci = scale(correl(0), sh_gain);
            cq = scale(correl(1), sh_gain);
            bi = 8'(ci);
            bq = 8'(cq);
            if (sh_snoop) begin
                bi[0] = hprev;
                bq[0] = hmid;
            end
            word = {bi, bq};
            hprev = h;
            e_ci = ci; e_cq = cq;
            wsel = subcarrier_sel; sh_gain = gain; sh_snoop = snoop;
            foreach (win[n]) win[n] = 0;
        end
        if (c == 32) hmid = h;
        win[c] = a;
        e_valid = c == 0;
        e_clk = c % 4 == 0 ? 1'b1 : c % 4 == 2 ? 1'b0 : e_clk;
        e_frame = c / 4 == 0 || c / 4 == 8;
        e_din = word[15 - c / 4];
        run_len = (h || run_len == 4095) ? 0 : run_len + 1;
        h = nh;
        cnt = (c + 1) % 64;
    endtask

    task automatic check_all();
        chk("corr_i", $signed(corr_i), e_ci);
        chk("corr_q", $signed(corr_q), e_cq);
        chk("corr_valid", corr_valid, e_valid);
        chk("ssp_clk", ssp_clk, e_clk);
        chk("ssp_frame", ssp_frame, e_frame);
        chk("ssp_din", ssp_din, e_din);
        chk("dbg", dbg, (cnt >> kbit(wsel)) & 1);
    endtask

    function automatic int gen(input int kind);
        int r;
        r = $urandom_range(0, 99);
        case (kind)
            1: return 128;
            2: return ((cnt >> 3) & 1) ? 0 : 255;
            3: return ((cnt >> 3) & 1) ? 255 : 0;
            4: return ((cnt >> 5) & 1) ? 0 : 255;
            5: return 0;
            default: return r < 10 ? 0 : r < 20 ? 255 : int'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic run(input int n, input int kind);
        int a;
        repeat (n) begin
            a = gen(kind);
            adc_d = 8'(a);
            @(posedge clk);
            model_edge(a);
            #1 check_all();
        end
    endtask

    initial begin
        reset_n = 1'b0; adc_d = '0; subcarrier_sel = 2'b00; gain = 2'b00; snoop = 1'b0;
        #1 run(3, 0);
        reset_n = 1'b1;
        subcarrier_sel = 2'b01; gain = 2'b10; snoop = 1'b1;
        run(100, 0);
        reset_n = 1'b0;
        run(10, 0);
        chk("rst_ci", $signed(corr_i), 0);
        chk("rst_frame", ssp_frame, 0);
        subcarrier_sel = 2'b00; gain = 2'b00; snoop = 1'b0;
        reset_n = 1'b1;
        run(1, 1);
        chk("first_valid", corr_valid, 1);
        chk("first_ci", $signed(corr_i), 0);
        run(63, 1);
        run(1, 2);
        chk("quiet_i", $signed(corr_i), 0);
        chk("quiet_q", $signed(corr_q), 0);
        chk("quiet_valid", corr_valid, 1);
        run(63, 2);
        gain = 2'b11;
        run(1, 2);
        chk("sq848_i", $signed(corr_i), 63);
        chk("sq848_q", $signed(corr_q), 0);
        run(63, 2);
        run(1, 3);
        chk("sat_hi", $signed(corr_i), 127);
        run(63, 3);
        gain = 2'b00;
        run(1, 2);
        chk("sat_lo", $signed(corr_i), -128);
        run(19, 2);
        subcarrier_sel = 2'b10;
        run(44, 2);
        run(1, 4);
        chk("capture_848", $signed(corr_i), 63);
        run(63, 4);
        run(1, 0);
        chk("sq212_i", $signed(corr_i), 63);
        chk("sq212_q", $signed(corr_q), 0);
        repeat (40) begin
            subcarrier_sel = 2'($urandom);
            gain = 2'($urandom);
            snoop = 1'($urandom);
            run($urandom_range(1, 80), 0);
        end
        subcarrier_sel = 2'b00; gain = 2'b00; snoop = 1'b1;
        run(5000, 5);
        run(130, 2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
